// File: rtl/pr_ctrl_pkg.sv
// pr_ctrl_pkg: shared types, MAC step order and saturation helper for the PR controller
package pr_ctrl_pkg;
  localparam int WIDTH_D = 16;
  localparam int COEF_W_D = 16;
  localparam int FRAC_D = 14;
  localparam int NCH_D = 4;
  localparam int GUARD_D = 4;
  localparam int ONE = 1 << FRAC_D;
  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_ADD, OP_SUB} mac_op_t;
  localparam logic [2:0] STEP_B0 = 3'd0;
  localparam logic [2:0] STEP_B2 = 3'd1;
  localparam logic [2:0] STEP_A1 = 3'd2;
  localparam logic [2:0] STEP_A2 = 3'd3;
  localparam logic [2:0] STEP_KP = 3'd4;
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pr_ctrl_mc_if.sv
// pr_ctrl_mc_if: error-frame input and per-channel result output bundle of pr_ctrl_mc
interface pr_ctrl_mc_if #(
  parameter int WIDTH = pr_ctrl_pkg::WIDTH_D,
  parameter int COEF_W = pr_ctrl_pkg::COEF_W_D,
  parameter int NCH = pr_ctrl_pkg::NCH_D
);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  logic in_valid;
  logic in_ready;
  logic [NCH*WIDTH-1:0] error_data;
  logic signed [COEF_W-1:0] kp, b0, b2, a1, a2;
  logic r_en;
  logic hist_clr;
  logic signed [WIDTH-1:0] result;
  logic [CH_W-1:0] result_ch;
  logic result_ready;
  logic frame_done;
  logic sat_flag;
  logic overrun;
  modport master (
    output in_valid, error_data, kp, b0, b2, a1, a2, r_en, hist_clr,
    input in_ready, result, result_ch, result_ready, frame_done, sat_flag, overrun
  );
  modport slave (
    input in_valid, error_data, kp, b0, b2, a1, a2, r_en, hist_clr,
    output in_ready, result, result_ch, result_ready, frame_done, sat_flag, overrun
  );
endinterface

// File: rtl/pr_mac_unit.sv
// pr_mac_unit: shared signed multiplier, wide accumulator and shift/saturate stage
module pr_mac_unit
  import pr_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int COEF_W = COEF_W_D,
  parameter int FRAC = FRAC_D,
  parameter int GUARD = GUARD_D
) (
  input logic clk_sys,
  input logic rst_n,
  input mac_op_t op,
  input logic yr_load,
  input logic r_en,
  input logic signed [WIDTH-1:0] a,
  input logic signed [COEF_W-1:0] b,
  output logic signed [WIDTH-1:0] yr,
  output logic signed [WIDTH-1:0] u,
  output logic clip
);
  localparam int ACC_W = WIDTH + COEF_W + GUARD;
  logic signed [WIDTH+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_nx, acc_sh, u_sum;
  logic signed [63:0] yr_full, u_full;
  logic yr_clip;
  always_comb begin
    prod = a * b;
    acc_nx = op == OP_LOAD ? ACC_W'(prod) :
             op == OP_ADD ? acc + ACC_W'(prod) :
             op == OP_SUB ? acc - ACC_W'(prod) : acc;
    acc_sh = acc >>> FRAC;
    yr_full = sat_w(64'(acc_sh), WIDTH);
    u_sum = acc_sh + ACC_W'(yr);
    u_full = sat_w(64'(u_sum), WIDTH);
    u = WIDTH'(u_full);
    clip = yr_clip | (u_full != 64'(u_sum));
  end
  // yr is captured as the kp product is loaded, so FIN sees both halves of u
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      yr <= '0;
      yr_clip <= 1'b0;
    end else begin
      acc <= acc_nx;
      if (yr_load) begin
        yr <= r_en ? WIDTH'(yr_full) : '0;
        yr_clip <= r_en & (yr_full != 64'(acc_sh));
      end
    end
endmodule

// File: rtl/pr_ctrl_mc.sv
// pr_ctrl_mc: multi-channel proportional-resonant controller, one MAC time-shared across channels
module pr_ctrl_mc
  import pr_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int COEF_W = COEF_W_D,
  parameter int FRAC = FRAC_D,
  parameter int NCH = NCH_D,
  parameter int GUARD = GUARD_D
) (
  input logic clk_sys,
  input logic rst_n,
  pr_ctrl_mc_if.slave bus
);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  state_t state, state_nx;
  logic [2:0] k;
  logic [CH_W-1:0] ch;
  logic [NCH*WIDTH-1:0] err_l;
  logic signed [COEF_W-1:0] kp_l, b0_l, b2_l, a1_l, a2_l, mul_b;
  logic r_en_l, clr_pend, accept, fin, last_ch, hist_wipe, clip;
  logic signed [WIDTH-1:0] e1 [NCH];
  logic signed [WIDTH-1:0] e2 [NCH];
  logic signed [WIDTH-1:0] y1 [NCH];
  logic signed [WIDTH-1:0] y2 [NCH];
  logic signed [WIDTH-1:0] e_cur, mul_a, yr, u;
  mac_op_t op;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.in_valid ? MAC : IDLE) :
               state == MAC ? (k == STEP_KP ? FIN : MAC) :
               (last_ch ? IDLE : MAC);
  always_comb begin
    accept = bus.in_valid & (state == IDLE);
    fin = state == FIN;
    last_ch = ch == CH_W'(NCH - 1);
    hist_wipe = (state == IDLE) & (bus.hist_clr | clr_pend);
    e_cur = err_l[int'(ch)*WIDTH +: WIDTH];
    mul_a = k == STEP_B2 ? e2[ch] : k == STEP_A1 ? y1[ch] : k == STEP_A2 ? y2[ch] : e_cur;
    mul_b = k == STEP_B0 ? b0_l : k == STEP_B2 ? b2_l : k == STEP_A1 ? a1_l :
            k == STEP_A2 ? a2_l : kp_l;
    op = state != MAC ? OP_HOLD : (k == STEP_B0 || k == STEP_KP) ? OP_LOAD :
         k == STEP_B2 ? OP_ADD : OP_SUB;
  end
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.result_ready = fin;
    bus.frame_done = fin & last_ch;
    bus.result = fin ? u : '0;
    bus.result_ch = fin ? ch : '0;
    bus.sat_flag = fin & clip;
    bus.overrun = bus.in_valid & (state != IDLE);
  end
  // a clear requested while busy waits here until the frame has finished
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      k <= '0;
      ch <= '0;
      err_l <= '0;
      {kp_l, b0_l, b2_l, a1_l, a2_l} <= '0;
      r_en_l <= 1'b0;
      clr_pend <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        e1[i] <= '0;
        e2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      clr_pend <= state == IDLE ? 1'b0 : clr_pend | bus.hist_clr;
      if (accept) begin
        err_l <= bus.error_data;
        {kp_l, b0_l, b2_l, a1_l, a2_l} <= {bus.kp, bus.b0, bus.b2, bus.a1, bus.a2};
        r_en_l <= bus.r_en;
        k <= STEP_B0;
        ch <= '0;
      end
      if (state == MAC) k <= k + 3'd1;
      if (fin) begin
        k <= STEP_B0;
        ch <= last_ch ? '0 : ch + 1'b1;
        e2[ch] <= e1[ch];
        e1[ch] <= e_cur;
        y2[ch] <= r_en_l ? y1[ch] : '0;
        y1[ch] <= yr;
      end
      if (hist_wipe)
        for (int i = 0; i < NCH; i++) begin
          e1[i] <= '0;
          e2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
    end
  pr_mac_unit #(.WIDTH(WIDTH), .COEF_W(COEF_W), .FRAC(FRAC), .GUARD(GUARD)) u_mac (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .op(op),
    .yr_load(state == MAC && k == STEP_KP),
    .r_en(r_en_l),
    .a(mul_a),
    .b(mul_b),
    .yr(yr),
    .u(u),
    .clip(clip)
  );
endmodule

// File: tb/tb_pr_ctrl_mc.sv
// tb_pr_ctrl_mc: vector table, corner sequences and random frames against a behavioural PR model
module tb_pr_ctrl_mc;
  import pr_ctrl_pkg::*;
  localparam int W = 16;
  localparam int CW = 16;
  localparam int FR = 14;
  localparam int N = 4;
  localparam int G = 4;
  typedef struct {
    logic [N*W-1:0] err;
    logic [15:0] kp, b0, b2, a1, a2;
    bit r_en, clr;
    logic [N*W-1:0] expv;
    logic [N-1:0] exps;
  } vec_t;
  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  longint me1[N], me2[N], my1[N], my2[N];
  longint exp_u[N];
  bit exp_s[N];
  vec_t tab[12];
  always #5 clk_sys = ~clk_sys;
  pr_ctrl_mc_if #(.WIDTH(W), .COEF_W(CW), .NCH(N)) bus ();
  pr_ctrl_mc #(.WIDTH(W), .COEF_W(CW), .FRAC(FR), .NCH(N), .GUARD(G)) dut (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [N*W-1:0] p4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction
  function automatic longint satw(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic void model_clear();
    for (int c = 0; c < N; c++) begin
      me1[c] = 0;
      me2[c] = 0;
      my1[c] = 0;
      my2[c] = 0;
    end
  endfunction
  function automatic void model_frame(input logic [N*W-1:0] err, input logic [15:0] kp, b0, b2, a1, a2,
                                      input bit r);
    longint e, res, yr, p;
    for (int c = 0; c < N; c++) begin
      e = longint'(signed'(err[c*W +: W]));
      res = longint'(signed'(b0)) * e + longint'(signed'(b2)) * me2[c]
          - longint'(signed'(a1)) * my1[c] - longint'(signed'(a2)) * my2[c];
      yr = r ? satw(res >>> FR) : 0;
      p = (longint'(signed'(kp)) * e) >>> FR;
      exp_u[c] = satw(p + yr);
      exp_s[c] = (r && yr != (res >>> FR)) || exp_u[c] != p + yr;
      me2[c] = me1[c];
      me1[c] = e;
      my2[c] = r ? my1[c] : 0;
      my1[c] = yr;
    end
  endfunction
  task automatic run_frame(input logic [N*W-1:0] err, input logic [15:0] kp, b0, b2, a1, a2,
                           input bit r, input bit clr, input bit hold, input bit rnd,
                           output logic [N*W-1:0] got_u, output logic [N-1:0] got_s);
    int j, idx, ovr, busy_rdy;
    bit pend, done;
    j = 0;
    while (bus.in_ready !== 1'b1 && j < 50) begin
      @(posedge clk_sys); #1;
      j++;
    end
    got_u = '0;
    got_s = '0;
    if (j == 50) begin
      check("idle_wait", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.error_data = err;
    {bus.kp, bus.b0, bus.b2, bus.a1, bus.a2} = {kp, b0, b2, a1, a2};
    bus.r_en = r;
    bus.hist_clr = clr;
    if (clr) model_clear();
    model_frame(err, kp, b0, b2, a1, a2, r);
    @(posedge clk_sys); #1;
    if (!hold) bus.in_valid = 1'b0;
    bus.hist_clr = 1'b0;
    idx = 0; ovr = 0; busy_rdy = 0; pend = 0; done = 0;
    for (j = 1; j <= 6*N + 10 && !done; j++) begin
      if (rnd) begin
        {bus.kp, bus.b0, bus.b2, bus.a1, bus.a2} = {16'($urandom), 16'($urandom), 16'($urandom),
                                                   16'($urandom), 16'($urandom)};
        bus.r_en = 1'($urandom);
        bus.error_data = {$urandom, $urandom};
        bus.hist_clr = $urandom_range(0, 11) == 0;
      end
      @(negedge clk_sys);
      if (bus.hist_clr) pend = 1;
      if (bus.overrun) ovr++;
      if (bus.in_ready) busy_rdy++;
      if (bus.result_ready) begin
        if (idx < N) begin
          check("rr_time", j, 6*(idx+1));
          check("rr_ch", bus.result_ch, idx);
          check("result", longint'(signed'(bus.result)), exp_u[idx]);
          check("sat_flag", bus.sat_flag, exp_s[idx]);
          check("frame_done", bus.frame_done, idx == N-1);
          got_u[idx*W +: W] = bus.result;
          got_s[idx] = bus.sat_flag;
        end
        idx++;
        if (bus.frame_done) done = 1;
      end else if (bus.frame_done) check("fd_without_rr", 1, 0);
      @(posedge clk_sys); #1;
    end
    bus.hist_clr = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
    check("result_count", idx, N);
    check("busy_in_ready", busy_rdy, 0);
    check("overrun_count", ovr, hold ? 6*N : 0);
    @(negedge clk_sys);
    check("in_ready_back", bus.in_ready, 1);
    check("overrun_idle", bus.overrun, 0);
    if (pend) model_clear();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [N*W-1:0] gu;
    logic [N-1:0] gs;
    int j, nrr;
    bus.in_valid = 1'b0;
    bus.error_data = '0;
    {bus.kp, bus.b0, bus.b2, bus.a1, bus.a2} = '0;
    bus.r_en = 1'b0;
    bus.hist_clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_sys);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_result_ready", bus.result_ready, 0);
    check("rst_result", bus.result, 0);
    check("rst_result_ch", bus.result_ch, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    tab[0] = '{p4(1000, -1000, 0, 32767), 16'(ONE), 16'h0, 16'h0, 16'h0, 16'h0, 1, 1,
               p4(1000, -1000, 0, 32767), 4'b0000};
    for (int i = 1; i <= 4; i++)
      tab[i] = '{p4(100, -50, 0, 0), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0,
                 p4(100*i, -50*i, 0, 0), 4'b0000};
    tab[5] = '{p4(100, -50, 0, 0), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 1,
               p4(100, -50, 0, 0), 4'b0000};
    tab[6] = '{p4(20000, -20000, 0, 1), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 1,
               p4(20000, -20000, 0, 1), 4'b0000};
    tab[7] = '{p4(20000, -20000, 0, 1), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0,
               p4(32767, -32768, 0, 2), 4'b0011};
    tab[8] = '{p4(-20000, 20000, 0, 1), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0,
               p4(12767, -12768, 0, 3), 4'b0000};
    tab[9] = '{p4(100, 100, 100, 100), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 0, 0,
               p4(0, 0, 0, 0), 4'b0000};
    tab[10] = '{p4(100, 0, 0, 0), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0,
                p4(100, 0, 0, 0), 4'b0000};
    tab[11] = '{p4(32767, -32768, 16384, -1), 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0,
                p4(32767, -32768, 32767, -2), 4'b0011};
    for (int i = 0; i < 12; i++) begin
      run_frame(tab[i].err, tab[i].kp, tab[i].b0, tab[i].b2, tab[i].a1, tab[i].a2,
                tab[i].r_en, tab[i].clr, 0, 0, gu, gs);
      for (int c = 0; c < N; c++) begin
        check($sformatf("tab%0d_ch%0d", i, c), longint'(signed'(gu[c*W +: W])),
              longint'(signed'(tab[i].expv[c*W +: W])));
        check($sformatf("tab%0d_sat%0d", i, c), gs[c], tab[i].exps[c]);
      end
    end
    run_frame(p4(100, 100, 100, 100), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0, 0, 0, gu, gs);
    @(posedge clk_sys); #1;
    bus.hist_clr = 1'b1;
    @(posedge clk_sys); #1;
    bus.hist_clr = 1'b0;
    model_clear();
    run_frame(p4(55, -3, 0, 9), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0, 0, 0, gu, gs);
    check("idle_clr", longint'(gu), longint'(p4(55, -3, 0, 9)));
    run_frame(p4(1, 2, 3, 4), 16'(ONE), 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 1, 0, gu, gs);
    run_frame(p4(5, 6, 7, 8), 16'(ONE), 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 0, 0, gu, gs);
    check("after_overrun", longint'(gu), longint'(p4(5, 6, 7, 8)));
    bus.in_valid = 1'b1;
    bus.error_data = p4(100, 100, 100, 100);
    {bus.kp, bus.b0, bus.b2, bus.a1, bus.a2} = {16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0};
    bus.r_en = 1'b1;
    @(posedge clk_sys); #1;
    bus.in_valid = 1'b0;
    j = 0; nrr = 0;
    while (nrr < 2 && j < 40) begin
      @(negedge clk_sys);
      if (bus.result_ready) nrr++;
      j++;
    end
    check("pre_reset_rr", nrr, 2);
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_rr", bus.result_ready, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_fd", bus.frame_done, 0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    model_clear();
    nrr = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (bus.result_ready) nrr++;
    end
    check("post_reset_rr", nrr, 0);
    check("post_reset_ready", bus.in_ready, 1);
    run_frame(p4(77, -77, 1, 0), 16'h0, 16'h4000, 16'h0, 16'hC000, 16'h0, 1, 0, 0, 0, gu, gs);
    check("post_reset_frame", longint'(gu), longint'(p4(77, -77, 1, 0)));
    for (int i = 0; i < 40; i++)
      run_frame({$urandom, $urandom}, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, 1, gu, gs);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
